// File: rtl/axi_pkg.sv
// AXI4 bus geometry and the request/response bundles between DMA master and responder.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package axi_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 512;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;
  localparam int AXI_ID_W   = 4;
  // log2 of the bus width in bytes; the widest legal AxSIZE
  localparam logic [2:0] AXI_BUS_SIZE = 3'($clog2(AXI_STRB_W));

  typedef struct packed {
    logic [AXI_ID_W-1:0]   awid;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  bready;
    logic [AXI_ID_W-1:0]   arid;
    logic [AXI_ADDR_W-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  rready;
  } axi_req_t;

  typedef struct packed {
    logic                  awready;
    logic                  wready;
    logic                  arready;
    logic [AXI_ID_W-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic [AXI_ID_W-1:0]   rid;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
  } axi_resp_t;

endpackage

// File: rtl/dma_pkg.sv
// Shared DMA encodings: burst/resp codes, responder FSM states, address helpers.
// Latency: n/a (types and pure functions).
// Backpressure: n/a (types and pure functions).
package dma_pkg;
  import axi_pkg::*;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} e_slv_rd_st_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} e_slv_wr_st_t;

  // First beat of a burst starts on a size-aligned address
  function automatic logic [AXI_ADDR_W-1:0] axi_align_addr(input logic [AXI_ADDR_W-1:0] addr,
                                                           input logic [2:0] size);
    return addr & ~((AXI_ADDR_W'(1) << size) - AXI_ADDR_W'(1));
  endfunction

  // INCR steps by the transfer size; FIXED (and the error-only WRAP) hold
  function automatic logic [AXI_ADDR_W-1:0] axi_next_addr(input logic [AXI_ADDR_W-1:0] addr,
                                                          input logic [2:0] size,
                                                          input logic [1:0] burst);
    return (burst == AXI_BURST_INCR) ? addr + (AXI_ADDR_W'(1) << size) : addr;
  endfunction

  // Encodings are ordered so the numerically larger code is the more severe
  function automatic logic [1:0] axi_worst_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dma_axi_slv_mem_array.sv
// 1R1W synchronous word array with per-byte write enables; read returns old data on collision.
// Latency: 1 cycle from re to rdata; rdata holds while re=0.
// Backpressure: none; caller gates re/we.
module dma_axi_slv_mem_array #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 512,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                re,
  input  logic [IDX_W-1:0]    raddr,
  output logic [DATA_W-1:0]   rdata,
  input  logic                we,
  input  logic [IDX_W-1:0]    waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write; storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Registered read port; nonblocking sampling yields pre-write data on same-word collision
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dma_axi_slv_mem.sv
// AXI4 responder memory: independent read/write burst FSMs over a byte-strobed array.
// Latency: R first beat RD_LAT cycles after AR handshake, then 1 beat/cycle; B 1 cycle after last W.
// Backpressure: rready/bready stalls hold R/B stable; one outstanding burst per direction.
module dma_axi_slv_mem
  import axi_pkg::*;
  import dma_pkg::*;
#(
  parameter int unsigned           MEM_BYTES = 65536,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned           RD_LAT    = 1
) (
  input  logic      clk,
  input  logic      rstn,
  input  axi_req_t  axi_req_i,
  output axi_resp_t axi_resp_o
);

  localparam int DEPTH = int'(MEM_BYTES) / AXI_STRB_W;
  localparam int IDX_W = $clog2(DEPTH);

  // Per-beat response; decode miss outranks burst/size errors
  function automatic logic [1:0] beat_resp(input logic [AXI_ADDR_W-1:0] addr,
                                           input logic [2:0] size, input logic [1:0] burst);
    if ((addr - BASE_ADDR) >= AXI_ADDR_W'(MEM_BYTES)) return AXI_DECERR;
    if ((burst != AXI_BURST_INCR && burst != AXI_BURST_FIXED) || size > AXI_BUS_SIZE)
      return AXI_SLVERR;
    return AXI_OKAY;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_W-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> AXI_BUS_SIZE);
  endfunction

  e_slv_rd_st_t          rd_st;
  logic [1:0]            rd_cnt;
  logic [AXI_ADDR_W-1:0] rd_addr;
  logic [7:0]            rd_len, rd_beat;
  logic [2:0]            rd_size;
  logic [1:0]            rd_burst, r_resp;
  logic [AXI_ID_W-1:0]   rd_id;
  logic                  ar_rdy, r_vld, r_last;
  logic                  rd_prime, rd_adv, rd_fetch;
  logic [AXI_ADDR_W-1:0] rd_faddr;
  logic [1:0]            rd_fresp;

  e_slv_wr_st_t          wr_st;
  logic [AXI_ADDR_W-1:0] wr_addr;
  logic [7:0]            wr_len, wr_beat;
  logic [2:0]            wr_size;
  logic [1:0]            wr_burst, wr_acc, b_resp;
  logic [AXI_ID_W-1:0]   wr_id;
  logic                  aw_rdy, w_rdy, b_vld;
  logic                  w_hs, w_is_last, mem_we;
  logic [1:0]            w_beat_resp, w_acc_next;

  logic [AXI_DATA_W-1:0] mem_rdata;

  // Read fetch: prime the first beat, or prefetch the next beat as the current one is taken
  always_comb begin
    rd_prime = (rd_st == R_DATA) && !r_vld;
    rd_adv   = (rd_st == R_DATA) && r_vld && axi_req_i.rready && (rd_beat != rd_len);
    rd_faddr = rd_prime ? rd_addr : axi_next_addr(rd_addr, rd_size, rd_burst);
    rd_fresp = beat_resp(rd_faddr, rd_size, rd_burst);
    rd_fetch = (rd_prime || rd_adv) && (rd_fresp == AXI_OKAY);
  end

  // Read FSM with registered AR/R outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_st <= R_IDLE;  rd_cnt <= '0;   rd_addr <= '0;  rd_len <= '0;  rd_beat <= '0;
      rd_size <= '0;    rd_burst <= '0; rd_id <= '0;    ar_rdy <= 1'b0;
      r_vld <= 1'b0;    r_last <= 1'b0; r_resp <= AXI_OKAY;
    end else begin
      case (rd_st)
        R_IDLE: begin
          if (ar_rdy && axi_req_i.arvalid) begin
            rd_addr  <= axi_align_addr(axi_req_i.araddr, axi_req_i.arsize);
            rd_len   <= axi_req_i.arlen;
            rd_size  <= axi_req_i.arsize;
            rd_burst <= axi_req_i.arburst;
            rd_id    <= axi_req_i.arid;
            rd_beat  <= '0;
            rd_cnt   <= '0;
            ar_rdy   <= 1'b0;
            rd_st    <= (RD_LAT > 1) ? R_LAT : R_DATA;
          end else begin
            ar_rdy <= 1'b1;
          end
        end
        R_LAT: begin
          if (rd_cnt == 2'(RD_LAT - 2)) rd_st <= R_DATA;
          else                          rd_cnt <= rd_cnt + 2'd1;
        end
        R_DATA: begin
          if (rd_prime) begin
            r_vld  <= 1'b1;
            r_resp <= rd_fresp;
            r_last <= (rd_len == 8'd0);
          end else if (axi_req_i.rready) begin
            if (rd_beat == rd_len) begin
              r_vld  <= 1'b0;
              r_last <= 1'b0;
              r_resp <= AXI_OKAY;
              ar_rdy <= 1'b1;
              rd_st  <= R_IDLE;
            end else begin
              rd_beat <= rd_beat + 8'd1;
              rd_addr <= rd_faddr;
              r_resp  <= rd_fresp;
              r_last  <= ((rd_beat + 8'd1) == rd_len);
            end
          end
        end
        default: rd_st <= R_IDLE;
      endcase
    end
  end

  // Write beat: commit only clean in-range beats; a wlast disagreeing with the count is SLVERR
  always_comb begin
    w_hs        = w_rdy && axi_req_i.wvalid;
    w_is_last   = (wr_beat == wr_len);
    w_beat_resp = beat_resp(wr_addr, wr_size, wr_burst);
    w_acc_next  = axi_worst_resp(wr_acc, w_beat_resp);
    if (axi_req_i.wlast != w_is_last) w_acc_next = axi_worst_resp(w_acc_next, AXI_SLVERR);
    mem_we      = w_hs && (w_beat_resp == AXI_OKAY);
  end

  // Write FSM with registered AW/W/B outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_st <= W_IDLE;  wr_addr <= '0;  wr_len <= '0;   wr_beat <= '0;  wr_size <= '0;
      wr_burst <= '0;   wr_id <= '0;    wr_acc <= AXI_OKAY;
      aw_rdy <= 1'b0;   w_rdy <= 1'b0;  b_vld <= 1'b0;  b_resp <= AXI_OKAY;
    end else begin
      case (wr_st)
        W_IDLE: begin
          if (aw_rdy && axi_req_i.awvalid) begin
            wr_addr  <= axi_align_addr(axi_req_i.awaddr, axi_req_i.awsize);
            wr_len   <= axi_req_i.awlen;
            wr_size  <= axi_req_i.awsize;
            wr_burst <= axi_req_i.awburst;
            wr_id    <= axi_req_i.awid;
            wr_beat  <= '0;
            wr_acc   <= AXI_OKAY;
            aw_rdy   <= 1'b0;
            w_rdy    <= 1'b1;
            wr_st    <= W_DATA;
          end else begin
            aw_rdy <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            if (w_is_last) begin
              w_rdy  <= 1'b0;
              b_vld  <= 1'b1;
              b_resp <= w_acc_next;
              wr_st  <= W_RESP;
            end else begin
              wr_beat <= wr_beat + 8'd1;
              wr_addr <= axi_next_addr(wr_addr, wr_size, wr_burst);
              wr_acc  <= w_acc_next;
            end
          end
        end
        W_RESP: begin
          if (axi_req_i.bready) begin
            b_vld  <= 1'b0;
            b_resp <= AXI_OKAY;
            aw_rdy <= 1'b1;
            wr_st  <= W_IDLE;
          end
        end
        default: wr_st <= W_IDLE;
      endcase
    end
  end

  dma_axi_slv_mem_array #(.DEPTH(DEPTH), .DATA_W(AXI_DATA_W), .IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .rstn  (rstn),
    .re    (rd_fetch),
    .raddr (word_idx(rd_faddr)),
    .rdata (mem_rdata),
    .we    (mem_we),
    .waddr (word_idx(wr_addr)),
    .wdata (axi_req_i.wdata),
    .wstrb (axi_req_i.wstrb)
  );

  // Pack registered channel state onto the response bundle
  always_comb begin
    axi_resp_o         = '0;
    axi_resp_o.awready = aw_rdy;
    axi_resp_o.wready  = w_rdy;
    axi_resp_o.arready = ar_rdy;
    axi_resp_o.bid     = wr_id;
    axi_resp_o.bresp   = b_resp;
    axi_resp_o.bvalid  = b_vld;
    axi_resp_o.rid     = rd_id;
    axi_resp_o.rdata   = mem_rdata;
    axi_resp_o.rresp   = r_resp;
    axi_resp_o.rlast   = r_last;
    axi_resp_o.rvalid  = r_vld;
  end

endmodule

// File: doc/dma_axi_slv_mem.md
# dma_axi_slv_mem

AXI4 responder (slave) memory that terminates the DMA engine's master AXI port; it is the far end of `axi_req_t`/`axi_resp_t`. It accepts INCR/FIXED read and write bursts and serves them from a byte-strobed on-chip array. It reports SLVERR/DECERR exactly as a real target would, and is the standard DMA integration and verification target.

## Interface
- `MEM_BYTES`, 65536: array size in bytes; power of two, multiple of bus bytes.
- `BASE_ADDR`, 0: first decoded byte address; aligned to `MEM_BYTES`.
- `RD_LAT`, 1: cycles from AR handshake to first R beat valid; allowed range 1..4.
- `clk`  in  1  clock; single clock domain.
- `rstn`  in  1  asynchronous, active-low reset.
- `axi_req_i`  in  `axi_req_t`  AW/W/AR channels plus `bready`/`rready` from the master.
- `axi_resp_o`  out  `axi_resp_t`  `awready`/`wready`/`arready` and the B/R channels.

## Operation
- Read and write paths are independent FSMs. Each has one outstanding burst; no interleaving.
- Read FSM: `R_IDLE` -> `R_LAT` -> `R_DATA` -> `R_IDLE`.
  - `R_IDLE`: `arready`=1. An AR handshake latches `araddr`, `arlen`, `arsize`, `arburst` and `arid`.
  - `R_LAT`: counts `RD_LAT-1` cycles. It is skipped when `RD_LAT`=1.
  - `R_DATA`: `rvalid`=1. A beat advances on `rvalid&rready`. `rlast`=1 when beat count equals `arlen`. Returns to `R_IDLE` after the last beat.
- Write FSM: `W_IDLE` -> `W_DATA` -> `W_RESP` -> `W_IDLE`.
  - `W_IDLE`: `awready`=1; AW is latched on handshake.
  - `W_DATA`: `wready`=1. Each `wvalid` beat writes bytes where `wstrb`=1.
  - `W_RESP`: `bvalid`=1 until `bready`; `bid` equals the latched `awid`.
- Address arithmetic:
  - INCR: next = addr + (1<<size), with the first beat aligned down to size.
  - FIXED: the address holds.
  - WRAP: the whole burst gets SLVERR and no array access.
  - The beat counter is 8 bits (`arlen`/`awlen` 0..255).
  - The array index is (addr-BASE_ADDR)>>log2(bus bytes), masked to the array depth. Byte lanes come from the low address bits.
- Errors:
  - A beat outside [BASE_ADDR, BASE_ADDR+MEM_BYTES) returns DECERR on that R beat. On the write side it suppresses the write and sets DECERR in B.
  - WRAP, or size > bus width, returns SLVERR.
  - B carries the worst response seen over the burst (DECERR > SLVERR > OKAY).
  - The burst always completes with the full beat count.
- The master's `wlast` is ignored for sequencing; the beat count is authoritative. If `wlast` mismatches the count, B is SLVERR.
- Read and write to the same word in the same cycle: the read returns the old data and the write lands.

## Timing
- Reset (`rstn`=0): every field of `axi_resp_o` is 0, both FSMs are in IDLE, all counters are 0.
- `arready`/`awready` rise on the first `clk` edge after `rstn` deasserts.
- Read latency: AR handshake at edge N gives `rvalid` at edge N+`RD_LAT`. Back-to-back beats then flow at 1 per cycle while `rready`=1.
- R holds `rdata`/`rresp`/`rlast` stable while `rvalid & !rready`.
- `wready` is valid from the cycle after the AW handshake. W beats presented before the AW handshake wait.
- `bvalid` rises the cycle after the last W handshake.
- Minimum inter-burst gap is 1 cycle on each path, because IDLE is re-entered before the next AX handshake.
- Reset asserted mid-burst aborts immediately with no response. The array contents are undefined afterwards and are not cleared.

## Structure
- Shared `dma_pkg` holds:
  - the burst and resp encodings (`AXI_BURST_FIXED/INCR/WRAP`, `AXI_OKAY/SLVERR/DECERR`);
  - the FSM state enums `e_slv_rd_st_t` and `e_slv_wr_st_t`;
  - the helper function `axi_next_addr(addr,size,burst)`.
- Bus widths come from `axi_pkg`.
- One sub-module, `dma_axi_slv_mem_array`: 1R1W synchronous array with per-byte write enable and read-old-data semantics. Only the array access is in the sub-module; both FSMs stay in the top.

## Test plan
- **Single read:** preload word 0 with 0xA5 pattern; AR addr=BASE, len=0, size=6 -> one R beat with the pattern, `rlast`=1, OKAY, `rid`=`arid`, `RD_LAT` cycles after the handshake.
- **INCR write then read:** AW len=15, size=6, all-ones strobes, incrementing data, then AR of the same range -> B OKAY, 16 R beats match, `rlast` only on beat 15.
- **Byte strobes:** write 0x11..; rewrite with `wstrb`=0x0F -> only bytes 0-3 change on readback.
- **Out of range:** AR at BASE+MEM_BYTES-64, len=1 -> beat 0 OKAY with data, beat 1 DECERR; write burst crossing the end -> B DECERR and in-range beats written.
- **Backpressure and WRAP:** random `rready`/`bready` stalls keep data stable and complete the burst; AR with WRAP len=3 -> 4 beats, all SLVERR.
- **Concurrency and reset:** simultaneous 256-beat read and write run to completion independently; `rstn` pulsed mid-read -> all outputs 0 and `arready`=1 the cycle after release.
